control_unit: RTL and testbench
===============================

# control_unit

Main decoder for the single-cycle RV32I core. It maps the fetched instruction's opcode, funct3 and bit 30 (funct7[5]), plus the ALU status flags, to every datapath control signal: register/memory write enables, immediate format, load/store width, ALU operand and operation selects, result source and next-PC select. Decode is purely combinational. A single reset-qualified enable register gates the architectural write enables.

## Interface
Parameters: none.
- clk — input, 1 bit — core clock, rising edge.
- rst_n — input, 1 bit — asynchronous, active-low reset.
- OPCode — input, 7 bits — instr[6:0].
- funct3 — input, 3 bits — instr[14:12].
- funct75 — input, 1 bit — instr[30].
- ALUFlags — input, 4 bits — {N, Z, C, V} from the ALU; C=1 means no borrow on subtract.
- regWrite — output, 1 bit — register-file write enable.
- immSource — output, 3 bits — immediate format: I=000, S=001, B=010, U=011, J=100.
- loadCtrl — output, 3 bits — load size/sign, equal to funct3 (LB 000, LH 001, LW 010, LBU 100, LHU 101).
- storeCtrl — output, 2 bits — store size: SB 00, SH 01, SW 10.
- srcAIn — output, 1 bit — ALU A operand: 0=rs1, 1=PC.
- srcBIn — output, 1 bit — ALU B operand: 0=rs2, 1=immediate.
- resultSource — output, 1 bit — write-back data: 0=ALU result, 1=load data.
- memWrite — output, 1 bit — data-memory write enable.
- PCNextIn — output, 1 bit — next PC: 0=PC+4, 1=branch/jump target.
- srcPCTarget — output, 1 bit — target-adder base: 0=PC, 1=rs1.
- ALUControl — output, 4 bits — ALU operation: ADD 0000, SUB 0001, SLL 0010, SLT 0011, SLTU 0100, XOR 0101, SRL 0110, SRA 0111, OR 1000, AND 1001, PASSB 1010, A+4 1011.

## Operation
- R-type (0110011): regWrite=1, srcA=0, srcB=0, result=0.
  - funct3 selects the ALU operation: 000 ADD (SUB if funct75=1), 001 SLL, 010 SLT, 011 SLTU, 100 XOR, 101 SRL (SRA if funct75=1), 110 OR, 111 AND.
  - funct75 is ignored except for funct3 000 and 101.
- I-ALU (0010011): as R-type except srcB=1, immSource=I.
  - funct75 is honoured only for funct3=101 (SRAI); ADDI never subtracts.
- Load (0000011): regWrite=1, srcB=1, immSource=I, ALU=ADD, result=1, loadCtrl=funct3.
- Store (0100011): memWrite=1, regWrite=0, srcB=1, immSource=S, ALU=ADD, storeCtrl=funct3[1:0]. funct75 is ignored.
- Branch (1100011): regWrite=0, immSource=B, srcA=0, srcB=0, ALU=SUB, srcPCTarget=0.
  - PCNextIn = taken, evaluated from ALUFlags.
  - BEQ Z; BNE !Z; BLT N^V; BGE !(N^V); BLTU !C; BGEU C.
  - funct3 010 and 011 are never taken.
- JAL (1101111): regWrite=1, immSource=J, srcA=1, ALU=A+4 (writes the link value), PCNextIn=1, srcPCTarget=0.
- JALR (1100111): as JAL but immSource=I and srcPCTarget=1.
- LUI (0110111): regWrite=1, immSource=U, srcB=1, ALU=PASSB.
- AUIPC (0010111): regWrite=1, immSource=U, srcA=1, srcB=1, ALU=ADD.
- Defaults: any output not listed for an opcode is 0, except loadCtrl=010 and storeCtrl=10 outside loads and stores.
- Unknown opcodes produce the all-default vector: no writes, PCNextIn=0, ALU=ADD.

## Timing
- All decode is combinational from the inputs within the same cycle. There is no added latency.
- An internal `valid` flop is cleared asynchronously while rst_n=0. It is set on the first rising clk edge with rst_n=1.
- While valid=0: regWrite, memWrite and PCNextIn are forced to 0. All other outputs still decode normally.
- Asserting rst_n mid-operation zeroes the three gated enables immediately, without waiting for a clock edge.
- ALUFlags affect only PCNextIn, and only for branch opcodes.

## Test plan
All vectors below are applied after reset release plus one clock edge.
- R-type SRL: OPCode=0110011, funct3=101, funct75=0 → regWrite=1, srcA=0, srcB=0, ALUControl=0110, result=0, memWrite=0, PCNextIn=0. With funct75=1 → ALUControl=0111.
- R-type SLTU with funct75 ignored: OPCode=0110011, funct3=011, funct75=1 → ALUControl=0100, regWrite=1.
- LBU: OPCode=0000011, funct3=100 → regWrite=1, immSource=000, loadCtrl=100, srcB=1, ALUControl=0000, resultSource=1, memWrite=0.
- SW with funct75 both ways: OPCode=0100011, funct3=010, funct75=1 then 0 → memWrite=1, regWrite=0, immSource=001, storeCtrl=10, srcB=1, ALUControl=0000 both times.
- Branches: BEQ with ALUFlags=0100 → PCNextIn=1, and with 0000 → 0. BLT with N=1,V=0 → 1. BGEU with C=0 → 0. JALR → PCNextIn=1, srcPCTarget=1, ALUControl=1011.
- Reset: hold rst_n=0 with an SW vector applied → memWrite=0, immSource=001. Release rst_n; memWrite stays 0 until the first rising clk edge, then becomes 1. Drop rst_n asynchronously → memWrite=0 immediately.

Source files
------------

// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Combinational RV32I main decoder with a reset-qualified enable
//            that gates the architectural write and redirect strobes.
// Revision : 1.0 - initial release
// ============================================================================
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [6:0] OPCode,
  input  logic [2:0] funct3,
  input  logic       funct75,
  input  logic [3:0] ALUFlags,
  output logic       regWrite,
  output logic [2:0] immSource,
  output logic [2:0] loadCtrl,
  output logic [1:0] storeCtrl,
  output logic       srcAIn,
  output logic       srcBIn,
  output logic       resultSource,
  output logic       memWrite,
  output logic       PCNextIn,
  output logic       srcPCTarget,
  output logic [3:0] ALUControl
);

  localparam logic [6:0] c_OP_R      = 7'b0110011;
  localparam logic [6:0] c_OP_I      = 7'b0010011;
  localparam logic [6:0] c_OP_LOAD   = 7'b0000011;
  localparam logic [6:0] c_OP_STORE  = 7'b0100011;
  localparam logic [6:0] c_OP_BRANCH = 7'b1100011;
  localparam logic [6:0] c_OP_JAL    = 7'b1101111;
  localparam logic [6:0] c_OP_JALR   = 7'b1100111;
  localparam logic [6:0] c_OP_LUI    = 7'b0110111;
  localparam logic [6:0] c_OP_AUIPC  = 7'b0010111;

  localparam logic [2:0] c_IMM_I = 3'b000;
  localparam logic [2:0] c_IMM_S = 3'b001;
  localparam logic [2:0] c_IMM_B = 3'b010;
  localparam logic [2:0] c_IMM_U = 3'b011;
  localparam logic [2:0] c_IMM_J = 3'b100;

  localparam logic [3:0] c_ALU_ADD   = 4'b0000;
  localparam logic [3:0] c_ALU_SUB   = 4'b0001;
  localparam logic [3:0] c_ALU_SLL   = 4'b0010;
  localparam logic [3:0] c_ALU_SLT   = 4'b0011;
  localparam logic [3:0] c_ALU_SLTU  = 4'b0100;
  localparam logic [3:0] c_ALU_XOR   = 4'b0101;
  localparam logic [3:0] c_ALU_SRL   = 4'b0110;
  localparam logic [3:0] c_ALU_SRA   = 4'b0111;
  localparam logic [3:0] c_ALU_OR    = 4'b1000;
  localparam logic [3:0] c_ALU_AND   = 4'b1001;
  localparam logic [3:0] c_ALU_PASSB = 4'b1010;
  localparam logic [3:0] c_ALU_APC4  = 4'b1011;

  logic       r_valid;
  logic       w_regWrite;
  logic       w_memWrite;
  logic       w_pcNext;
  logic       w_taken;
  logic [3:0] w_aluOp;
  logic       w_flagN;
  logic       w_flagZ;
  logic       w_flagC;
  logic       w_flagV;

  assign {w_flagN, w_flagZ, w_flagC, w_flagV} = ALUFlags;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
    end else begin
      r_valid <= 1'b1;
    end
  end

  // Shared R/I ALU op; only R-type may turn ADD into SUB.
  always_comb begin
    w_aluOp = c_ALU_ADD;
    unique case (funct3)
      3'b000:  w_aluOp = (funct75 && (OPCode == c_OP_R)) ? c_ALU_SUB : c_ALU_ADD;
      3'b001:  w_aluOp = c_ALU_SLL;
      3'b010:  w_aluOp = c_ALU_SLT;
      3'b011:  w_aluOp = c_ALU_SLTU;
      3'b100:  w_aluOp = c_ALU_XOR;
      3'b101:  w_aluOp = funct75 ? c_ALU_SRA : c_ALU_SRL;
      3'b110:  w_aluOp = c_ALU_OR;
      default: w_aluOp = c_ALU_AND;
    endcase
  end

  always_comb begin
    w_taken = 1'b0;
    unique case (funct3)
      3'b000:  w_taken = w_flagZ;
      3'b001:  w_taken = ~w_flagZ;
      3'b100:  w_taken = w_flagN ^ w_flagV;
      3'b101:  w_taken = ~(w_flagN ^ w_flagV);
      3'b110:  w_taken = ~w_flagC;
      3'b111:  w_taken = w_flagC;
      default: w_taken = 1'b0;
    endcase
  end

  always_comb begin
    w_regWrite   = 1'b0;
    w_memWrite   = 1'b0;
    w_pcNext     = 1'b0;
    immSource    = c_IMM_I;
    loadCtrl     = 3'b010;
    storeCtrl    = 2'b10;
    srcAIn       = 1'b0;
    srcBIn       = 1'b0;
    resultSource = 1'b0;
    srcPCTarget  = 1'b0;
    ALUControl   = c_ALU_ADD;
    case (OPCode)
      c_OP_R: begin
        w_regWrite = 1'b1;
        ALUControl = w_aluOp;
      end
      c_OP_I: begin
        w_regWrite = 1'b1;
        srcBIn     = 1'b1;
        ALUControl = w_aluOp;
      end
      c_OP_LOAD: begin
        w_regWrite   = 1'b1;
        srcBIn       = 1'b1;
        resultSource = 1'b1;
        loadCtrl     = funct3;
      end
      c_OP_STORE: begin
        w_memWrite = 1'b1;
        srcBIn     = 1'b1;
        immSource  = c_IMM_S;
        storeCtrl  = funct3[1:0];
      end
      c_OP_BRANCH: begin
        immSource  = c_IMM_B;
        ALUControl = c_ALU_SUB;
        w_pcNext   = w_taken;
      end
      c_OP_JAL: begin
        w_regWrite = 1'b1;
        immSource  = c_IMM_J;
        srcAIn     = 1'b1;
        ALUControl = c_ALU_APC4;
        w_pcNext   = 1'b1;
      end
      c_OP_JALR: begin
        w_regWrite  = 1'b1;
        srcAIn      = 1'b1;
        ALUControl  = c_ALU_APC4;
        w_pcNext    = 1'b1;
        srcPCTarget = 1'b1;
      end
      c_OP_LUI: begin
        w_regWrite = 1'b1;
        immSource  = c_IMM_U;
        srcBIn     = 1'b1;
        ALUControl = c_ALU_PASSB;
      end
      c_OP_AUIPC: begin
        w_regWrite = 1'b1;
        immSource  = c_IMM_U;
        srcAIn     = 1'b1;
        srcBIn     = 1'b1;
      end
      default: begin
        w_regWrite = 1'b0;
      end
    endcase
  end

  // r_valid clears asynchronously, so the gated strobes drop without a clock.
  assign regWrite = w_regWrite & r_valid;
  assign memWrite = w_memWrite & r_valid;
  assign PCNextIn = w_pcNext & r_valid;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed-vector self-checking bench for control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [6:0] OPCode;
  logic [2:0] funct3;
  logic       funct75;
  logic [3:0] ALUFlags;
  logic       regWrite;
  logic [2:0] immSource;
  logic [2:0] loadCtrl;
  logic [1:0] storeCtrl;
  logic       srcAIn;
  logic       srcBIn;
  logic       resultSource;
  logic       memWrite;
  logic       PCNextIn;
  logic       srcPCTarget;
  logic [3:0] ALUControl;

  int nVec = 0;
  int nErr = 0;

  control_unit dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .OPCode      (OPCode),
    .funct3      (funct3),
    .funct75     (funct75),
    .ALUFlags    (ALUFlags),
    .regWrite    (regWrite),
    .immSource   (immSource),
    .loadCtrl    (loadCtrl),
    .storeCtrl   (storeCtrl),
    .srcAIn      (srcAIn),
    .srcBIn      (srcBIn),
    .resultSource(resultSource),
    .memWrite    (memWrite),
    .PCNextIn    (PCNextIn),
    .srcPCTarget (srcPCTarget),
    .ALUControl  (ALUControl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    nVec++;
    assert (obs === exp) else begin
      nErr++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Drive on the falling edge, then let the combinational decode settle.
  task automatic apply(input logic [6:0] op, input logic [2:0] f3, input logic f75,
                       input logic [3:0] flags);
    @(negedge clk);
    OPCode   = op;
    funct3   = f3;
    funct75  = f75;
    ALUFlags = flags;
    #1;
  endtask

  initial begin
    rst_n    = 1'b0;
    OPCode   = 7'b0100011;
    funct3   = 3'b010;
    funct75  = 1'b0;
    ALUFlags = 4'b0000;

    // Reset held with SW applied: strobes gated, decode live.
    #12;
    check("rst_memWrite",  {3'b0, memWrite},  4'd0);
    check("rst_regWrite",  {3'b0, regWrite},  4'd0);
    check("rst_immSource", {1'b0, immSource}, 4'b0001);
    check("rst_storeCtrl", {2'b0, storeCtrl}, 4'b0010);

    // Release between edges; memWrite waits for the next rising edge.
    rst_n = 1'b1;
    #1;
    check("rel_memWrite_pre", {3'b0, memWrite}, 4'd0);
    @(posedge clk);
    #1;
    check("rel_memWrite_post", {3'b0, memWrite}, 4'd1);

    apply(7'b0110011, 3'b101, 1'b0, 4'b0000);
    check("srl_regWrite", {3'b0, regWrite},     4'd1);
    check("srl_srcA",     {3'b0, srcAIn},       4'd0);
    check("srl_srcB",     {3'b0, srcBIn},       4'd0);
    check("srl_alu",      ALUControl,           4'b0110);
    check("srl_result",   {3'b0, resultSource}, 4'd0);
    check("srl_memWrite", {3'b0, memWrite},     4'd0);
    check("srl_pcNext",   {3'b0, PCNextIn},     4'd0);

    apply(7'b0110011, 3'b101, 1'b1, 4'b0000);
    check("sra_alu", ALUControl, 4'b0111);

    apply(7'b0110011, 3'b000, 1'b1, 4'b0000);
    check("sub_alu", ALUControl, 4'b0001);

    apply(7'b0110011, 3'b011, 1'b1, 4'b0000);
    check("sltu_alu",      ALUControl,       4'b0100);
    check("sltu_regWrite", {3'b0, regWrite}, 4'd1);

    apply(7'b0010011, 3'b000, 1'b1, 4'b0000);
    check("addi_alu",  ALUControl,         4'b0000);
    check("addi_srcB", {3'b0, srcBIn},     4'd1);

    apply(7'b0010011, 3'b101, 1'b1, 4'b0000);
    check("srai_alu", ALUControl, 4'b0111);

    apply(7'b0000011, 3'b100, 1'b0, 4'b0000);
    check("lbu_regWrite",  {3'b0, regWrite},     4'd1);
    check("lbu_immSource", {1'b0, immSource},    4'b0000);
    check("lbu_loadCtrl",  {1'b0, loadCtrl},     4'b0100);
    check("lbu_srcB",      {3'b0, srcBIn},       4'd1);
    check("lbu_alu",       ALUControl,           4'b0000);
    check("lbu_result",    {3'b0, resultSource}, 4'd1);
    check("lbu_memWrite",  {3'b0, memWrite},     4'd0);
    check("lbu_storeCtrl", {2'b0, storeCtrl},    4'b0010);

    for (int k = 0; k < 2; k++) begin
      apply(7'b0100011, 3'b010, (k == 0), 4'b0000);
      check("sw_memWrite",  {3'b0, memWrite},  4'd1);
      check("sw_regWrite",  {3'b0, regWrite},  4'd0);
      check("sw_immSource", {1'b0, immSource}, 4'b0001);
      check("sw_storeCtrl", {2'b0, storeCtrl}, 4'b0010);
      check("sw_srcB",      {3'b0, srcBIn},    4'd1);
      check("sw_alu",       ALUControl,        4'b0000);
    end

    apply(7'b0100011, 3'b000, 1'b0, 4'b0000);
    check("sb_storeCtrl", {2'b0, storeCtrl}, 4'b0000);
    check("sb_loadCtrl",  {1'b0, loadCtrl},  4'b0010);

    apply(7'b1100011, 3'b000, 1'b0, 4'b0100);
    check("beq_taken",     {3'b0, PCNextIn},  4'd1);
    check("beq_alu",       ALUControl,        4'b0001);
    check("beq_immSource", {1'b0, immSource}, 4'b0010);
    check("beq_regWrite",  {3'b0, regWrite},  4'd0);
    apply(7'b1100011, 3'b000, 1'b0, 4'b0000);
    check("beq_not_taken", {3'b0, PCNextIn}, 4'd0);
    apply(7'b1100011, 3'b001, 1'b0, 4'b0000);
    check("bne_taken", {3'b0, PCNextIn}, 4'd1);
    apply(7'b1100011, 3'b100, 1'b0, 4'b1000);
    check("blt_taken", {3'b0, PCNextIn}, 4'd1);
    apply(7'b1100011, 3'b100, 1'b0, 4'b1001);
    check("blt_nv_not_taken", {3'b0, PCNextIn}, 4'd0);
    apply(7'b1100011, 3'b101, 1'b0, 4'b1001);
    check("bge_taken", {3'b0, PCNextIn}, 4'd1);
    apply(7'b1100011, 3'b110, 1'b0, 4'b0000);
    check("bltu_taken", {3'b0, PCNextIn}, 4'd1);
    apply(7'b1100011, 3'b111, 1'b0, 4'b0000);
    check("bgeu_not_taken", {3'b0, PCNextIn}, 4'd0);
    apply(7'b1100011, 3'b111, 1'b0, 4'b0010);
    check("bgeu_taken", {3'b0, PCNextIn}, 4'd1);
    apply(7'b1100011, 3'b010, 1'b0, 4'b1111);
    check("b010_never", {3'b0, PCNextIn}, 4'd0);
    apply(7'b1100011, 3'b011, 1'b0, 4'b0000);
    check("b011_never", {3'b0, PCNextIn}, 4'd0);

    apply(7'b1101111, 3'b000, 1'b0, 4'b0000);
    check("jal_pcNext",    {3'b0, PCNextIn},    4'd1);
    check("jal_immSource", {1'b0, immSource},   4'b0100);
    check("jal_srcA",      {3'b0, srcAIn},      4'd1);
    check("jal_alu",       ALUControl,          4'b1011);
    check("jal_pcTarget",  {3'b0, srcPCTarget}, 4'd0);
    check("jal_regWrite",  {3'b0, regWrite},    4'd1);

    apply(7'b1100111, 3'b000, 1'b0, 4'b0000);
    check("jalr_pcNext",    {3'b0, PCNextIn},    4'd1);
    check("jalr_pcTarget",  {3'b0, srcPCTarget}, 4'd1);
    check("jalr_alu",       ALUControl,          4'b1011);
    check("jalr_immSource", {1'b0, immSource},   4'b0000);

    apply(7'b0110111, 3'b000, 1'b0, 4'b0000);
    check("lui_alu",       ALUControl,        4'b1010);
    check("lui_immSource", {1'b0, immSource}, 4'b0011);
    check("lui_srcA",      {3'b0, srcAIn},    4'd0);

    apply(7'b0010111, 3'b000, 1'b0, 4'b0000);
    check("auipc_srcA", {3'b0, srcAIn},  4'd1);
    check("auipc_srcB", {3'b0, srcBIn},  4'd1);
    check("auipc_alu",  ALUControl,      4'b0000);

    apply(7'b1111111, 3'b111, 1'b1, 4'b1111);
    check("unk_regWrite",  {3'b0, regWrite},  4'd0);
    check("unk_memWrite",  {3'b0, memWrite},  4'd0);
    check("unk_pcNext",    {3'b0, PCNextIn},  4'd0);
    check("unk_alu",       ALUControl,        4'b0000);
    check("unk_loadCtrl",  {1'b0, loadCtrl},  4'b0010);
    check("unk_storeCtrl", {2'b0, storeCtrl}, 4'b0010);

    // Asynchronous reset mid-cycle with a store and a jump.
    apply(7'b0100011, 3'b010, 1'b0, 4'b0000);
    check("pre_async_memWrite", {3'b0, memWrite}, 4'd1);
    #1;
    rst_n = 1'b0;
    #1;
    check("async_memWrite", {3'b0, memWrite}, 4'd0);
    OPCode = 7'b1101111;
    #1;
    check("async_pcNext",   {3'b0, PCNextIn}, 4'd0);
    check("async_regWrite", {3'b0, regWrite}, 4'd0);
    check("async_alu",      ALUControl,       4'b1011);

    $display("== %0d vectors applied, %0d miscompares ==", nVec, nErr);
    $finish;
  end

endmodule
`default_nettype wire
